fp16_mul_stream: RTL and testbench

//  Streaming front/back stage around the fp16 multiplier datapath.

---
 rtl/fp16_pkg.sv | 66 ++++++
 rtl/fp16_mul_stream_if.sv | 22 ++
 rtl/fp16_sync_fifo.sv | 63 ++++++
 rtl/fp16_mul_stream.sv | 127 ++++++++++++
 tb/tb_fp16_mul_stream.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: operand classes, special constants, flag bit positions
// and the special-case result selection used by the streaming multiplier wrapper.
package fp16_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp16_cls_e;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_INF     = 1;
  localparam int FLAG_INVALID = 2;

  typedef struct packed {
    logic        special;
    logic [2:0]  flags;
    logic [15:0] x;
  } fp16_sp_t;

  // Subnormals classify as zero so they are flushed by the result mux.
  function automatic fp16_cls_e fp16_class(input logic [15:0] v);
    fp16_cls_e c;
    if (v[14:10] == 5'd0) begin
      c = CLS_ZERO;
    end else if (v[14:10] == FP16_EXP_MAX) begin
      c = (v[9:0] == 10'd0) ? CLS_INF : CLS_NAN;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

  function automatic fp16_sp_t fp16_special(input logic [15:0] a, input logic [15:0] b);
    fp16_sp_t  r;
    fp16_cls_e ca;
    fp16_cls_e cb;
    logic      s;
    ca = fp16_class(a);
    cb = fp16_class(b);
    s  = a[15] ^ b[15];
    r  = '0;
    if (ca == CLS_NAN || cb == CLS_NAN ||
        (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
      r.special             = 1'b1;
      r.flags[FLAG_INVALID] = 1'b1;
      r.x                   = FP16_QNAN;
    end else if (ca == CLS_INF || cb == CLS_INF) begin
      r.special         = 1'b1;
      r.flags[FLAG_INF] = 1'b1;
      r.x               = {s, FP16_EXP_MAX, 10'h000};
    end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
      r.special          = 1'b1;
      r.flags[FLAG_ZERO] = 1'b1;
      r.x                = {s, 15'h0000};
    end else begin
      r.special = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp16_mul_stream_if.sv
// Operand input stream and result output stream of fp16_mul_stream.
// master = producer/consumer side, slave = the streaming multiplier block.
interface fp16_mul_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_x, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_x, out_flags
  );
endinterface

// File: rtl/fp16_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a write while full is accepted when
// the same cycle also pops, so a full FIFO can stream at one entry per cycle.
module fp16_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_rd_s = rd_en && !empty;
  assign do_wr_s = wr_en && (!full || do_rd_s);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_wr_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/fp16_mul_stream.sv
// Streaming wrapper around an external 1-cycle fp16 multiplier: operand FIFO,
// credit-limited issue, two tracking stages, special-case substitution, result FIFO.
module fp16_mul_stream
  import fp16_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  fp16_mul_stream_if.slave   bus,
  output logic [15:0]        mul_a,
  output logic [15:0]        mul_b,
  input  logic [15:0]        mul_x
);
  localparam int OCW = $clog2(DEPTH) + 1;
  localparam int RCW = $clog2(RDEPTH) + 1;
  localparam logic [RCW:0] CREDIT_MAX = (RCW + 1)'(RDEPTH);

  logic [31:0]    op_rd_s;
  logic           op_full_s, op_empty_s;
  logic [OCW-1:0] op_count_s;
  logic [18:0]    res_wr_s, res_rd_s;
  logic           res_full_s, res_empty_s;
  logic [RCW-1:0] res_count_s;
  logic [RCW:0]   inflight_s;
  logic           issue_s;
  logic           push_s;
  logic           pop_s;
  logic           unused_ok_s;

  logic           rdy_q, rdy_d;
  logic           s1_v_q, s1_v_d;
  logic           s2_v_q, s2_v_d;
  fp16_sp_t       s1_sp_q, s1_sp_d;
  fp16_sp_t       s2_sp_q, s2_sp_d;
  logic [15:0]    mul_a_q, mul_a_d;
  logic [15:0]    mul_b_q, mul_b_d;

  assign bus.in_ready  = rdy_q && !op_full_s;
  assign push_s        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = !res_empty_s;
  assign pop_s         = bus.out_valid && bus.out_ready;
  assign bus.out_x     = res_rd_s[15:0];
  assign bus.out_flags = res_rd_s[18:16];
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign unused_ok_s   = ^{op_count_s, res_full_s};

  fp16_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_op_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_s),
    .wr_data ({bus.in_a, bus.in_b}),
    .rd_en   (issue_s),
    .rd_data (op_rd_s),
    .full    (op_full_s),
    .empty   (op_empty_s),
    .count   (op_count_s)
  );

  fp16_sync_fifo #(.WIDTH(19), .DEPTH(RDEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s2_v_q),
    .wr_data (res_wr_s),
    .rd_en   (pop_s),
    .rd_data (res_rd_s),
    .full    (res_full_s),
    .empty   (res_empty_s),
    .count   (res_count_s)
  );

  // Every issued op owns a result slot until popped, so writeback never overflows.
  always_comb begin
    inflight_s = {1'b0, res_count_s} + {{RCW{1'b0}}, s1_v_q} + {{RCW{1'b0}}, s2_v_q};
    issue_s    = !op_empty_s && (inflight_s < CREDIT_MAX);
  end

  always_comb begin
    rdy_d   = 1'b1;
    s1_v_d  = issue_s;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    s1_sp_d = s1_sp_q;
    if (issue_s) begin
      mul_a_d = op_rd_s[31:16];
      mul_b_d = op_rd_s[15:0];
      s1_sp_d = fp16_special(op_rd_s[31:16], op_rd_s[15:0]);
    end else begin
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      s1_sp_d = s1_sp_q;
    end
    s2_v_d  = s1_v_q;
    s2_sp_d = s1_sp_q;
  end

  always_comb begin
    res_wr_s = {3'b000, mul_x};
    if (s2_sp_q.special) begin
      res_wr_s = {s2_sp_q.flags, s2_sp_q.x};
    end else begin
      res_wr_s = {3'b000, mul_x};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q   <= 1'b0;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s1_sp_q <= '0;
      s2_sp_q <= '0;
      mul_a_q <= 16'h0000;
      mul_b_q <= 16'h0000;
    end else begin
      rdy_q   <= rdy_d;
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      s1_sp_q <= s1_sp_d;
      s2_sp_q <= s2_sp_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end
endmodule

// File: tb/tb_fp16_mul_stream.sv
// Randomized and directed bench for fp16_mul_stream with a behavioural fp16
// multiplier and a queue-based reference model of the special-case rules.
module tb_fp16_mul_stream;
  logic        clk;
  logic        rst;
  logic [15:0] mul_a, mul_b, mul_x;

  fp16_mul_stream_if bus();

  fp16_mul_stream #(.DEPTH(4), .RDEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_x (mul_x)
  );

  int          checks;
  int          failures;
  int          cyc;
  logic        accepted;
  logic        d_v;
  logic        d_rdy;
  int          rdy_mode;
  logic [15:0] d_a, d_b;
  logic [18:0] d_exp;
  logic [18:0] exp_q[$];
  int          pop_log[$];
  int          pops;
  logic        wr_full_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-to-nearest-even product of two normal fp16 values, flushing underflow.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    int e, prod, sh, mant, rem, half;
    logic s;
    logic [15:0] r;
    s    = a[15] ^ b[15];
    e    = int'(a[14:10]) + int'(b[14:10]) - 15;
    prod = int'({1'b1, a[9:0]}) * int'({1'b1, b[9:0]});
    if (prod >= (1 << 21)) begin
      sh = 11;
      e  = e + 1;
    end else begin
      sh = 10;
    end
    mant = prod >> sh;
    rem  = prod & ((1 << sh) - 1);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (mant & 1) == 1)) mant = mant + 1;
    if (mant == 2048) begin
      mant = 1024;
      e    = e + 1;
    end
    if (e >= 31)     r = {s, 5'h1F, 10'h000};
    else if (e <= 0) r = {s, 15'h0000};
    else             r = {s, e[4:0], mant[9:0]};
    return r;
  endfunction

  function automatic logic [18:0] ref_model(input logic [15:0] a, input logic [15:0] b);
    logic s, za, zb, ia, ib, na, nb;
    s  = a[15] ^ b[15];
    za = (a[14:10] == 5'd0);
    zb = (b[14:10] == 5'd0);
    ia = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    ib = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    na = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    nb = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 16'h7E00};
    if (ia || ib)                             return {3'b010, s, 5'h1F, 10'h000};
    if (za || zb)                             return {3'b001, s, 15'h0000};
    return {3'b000, fmul(a, b)};
  endfunction

  function automatic logic [15:0] rand_op(input logic normal_only);
    int unsigned k;
    logic [15:0] v;
    k = normal_only ? 32'd9 : $urandom_range(0, 9);
    v = 16'($urandom);
    case (k)
      0: v[14:10] = 5'd0;
      1: begin v[14:10] = 5'h1F; v[9:0] = 10'd0; end
      2: begin v[14:10] = 5'h1F; if (v[9:0] == 10'd0) v[0] = 1'b1; end
      default: v[14:10] = 5'($urandom_range(8, 22));
    endcase
    return v;
  endfunction

  // Stand-in for the external multiplier: one registered cycle, shares rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mul_x <= 16'h0000;
    else      mul_x <= fmul(mul_a, mul_b);
  end

  always @(posedge clk) begin
    if (rst && dut.s2_v_q && dut.u_res_fifo.full && !(bus.out_valid && bus.out_ready))
      wr_full_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [18:0] e;
    @(negedge clk);
    case (rdy_mode)
      1:       d_rdy = !d_rdy;
      2:       d_rdy = 1'($urandom_range(0, 1));
      default: d_rdy = d_rdy;
    endcase
    bus.in_valid  = d_v;
    bus.in_a      = d_a;
    bus.in_b      = d_b;
    bus.out_ready = d_rdy;
    #1;
    cyc++;
    accepted = bus.in_valid && bus.in_ready;
    if (accepted) exp_q.push_back(d_exp);
    if (bus.out_valid && bus.out_ready) begin
      pops++;
      pop_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_x", {16'b0, bus.out_x}, {16'b0, e[15:0]});
        check_eq("out_flags", {29'b0, bus.out_flags}, {29'b0, e[18:16]});
      end
    end
  endtask

  task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic [18:0] e);
    d_v = 1'b1; d_a = a; d_b = b; d_exp = e;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (accepted) break;
    end
    check_eq("accepted", {31'b0, accepted}, 32'd1);
    d_v = 1'b0;
  endtask

  task automatic offer_rand(input logic normal_only);
    logic [15:0] a, b;
    a = rand_op(normal_only);
    b = rand_op(normal_only);
    offer(a, b, ref_model(a, b));
  endtask

  task automatic drain();
    d_v = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    check_eq("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int k, idx;
    logic [15:0] ta[10], tb[10];
    checks = 0; failures = 0; cyc = 0; pops = 0; wr_full_seen = 1'b0;
    d_v = 1'b0; d_rdy = 1'b1; rdy_mode = 0; d_a = '0; d_b = '0; d_exp = '0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("rst_out_x", {13'b0, bus.out_flags, bus.out_x}, 32'd0);
    check_eq("rst_mul_ab", {mul_a, mul_b}, 32'd0);
    rst = 1'b1;
    cycle();
    check_eq("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // 1: single op and minimum latency
    offer(16'h3C00, 16'h3C00, {3'b000, 16'h3C00});
    k = cyc;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.out_valid) break;
    end
    check_eq("latency", cyc - k - 1, 32'd3);
    drain();

    // 2: back-to-back normals, one result per cycle
    pop_log.delete();
    offer(16'h4000, 16'h4200, {3'b000, 16'h4600});
    offer(16'hBC00, 16'h4000, {3'b000, 16'hC000});
    offer(16'h3800, 16'h3800, {3'b000, 16'h3400});
    drain();
    check_eq("b2b_count", pop_log.size(), 32'd3);
    check_eq("b2b_gap0", pop_log[1] - pop_log[0], 32'd1);
    check_eq("b2b_gap1", pop_log[2] - pop_log[1], 32'd1);

    // 3: special cases
    offer(16'h7C00, 16'h0000, {3'b100, 16'h7E00});
    offer(16'h7E01, 16'h3C00, {3'b100, 16'h7E00});
    offer(16'hFC00, 16'h4000, {3'b010, 16'hFC00});
    offer(16'h8000, 16'h4500, {3'b001, 16'h8000});
    offer(16'h0001, 16'h3C00, {3'b001, 16'h0000});
    drain();

    // 4: backpressure fills both FIFOs
    for (int i = 0; i < 10; i++) begin
      ta[i] = rand_op(1'b1);
      tb[i] = rand_op(1'b1);
    end
    d_rdy = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      d_v = (idx < 10);
      d_a = ta[idx % 10]; d_b = tb[idx % 10]; d_exp = ref_model(d_a, d_b);
      cycle();
      if (accepted) idx++;
    end
    d_v = 1'b0;
    check_eq("bp_accepted", idx, 32'd8);
    check_eq("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    pops = 0;
    d_rdy = 1'b1;
    drain();
    check_eq("bp_drained", pops, 32'd8);

    // 5: toggling and random out_ready under continuous input
    rdy_mode = 1;
    for (int n = 0; n < 150; n++) offer_rand(1'b0);
    rdy_mode = 0; d_rdy = 1'b1;
    drain();
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) offer_rand(1'b0);
    rdy_mode = 0; d_rdy = 1'b1;
    drain();

    // 6: reset with work queued and in flight
    d_rdy = 1'b0;
    for (int n = 0; n < 5; n++) offer_rand(1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check_eq("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    d_rdy = 1'b1;
    cycle();
    check_eq("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check_eq("rel_out_valid", {31'b0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 10; i++) cycle();
    check_eq("no_stale", {31'b0, bus.out_valid}, 32'd0);
    offer(16'h3C00, 16'h3C00, {3'b000, 16'h3C00});
    drain();

    check_eq("no_write_when_full", {31'b0, wr_full_seen}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
